// File: rtl/mimi_sram_arbiter.sv
// Banked SRAM controller arbitrating a CPU data port and a Wishbone slave port.
// Byte-masked writes are done as read-modify-write because the macros only take full words.
module mimi_sram_arbiter #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_WORDS = 512,
    parameter logic [15:0] WB_BASE    = 16'h3000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          cpu_req,
    input  logic [31:0]                   cpu_addr,
    input  logic [3:0]                    cpu_wmask,
    input  logic [31:0]                   cpu_wdata,
    output logic [31:0]                   cpu_rdata,
    output logic                          cpu_ack,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic [31:0]                   wbs_dat_o,
    output logic                          wbs_ack_o,
    output logic [NUM_BANKS-1:0]          sram_en,
    output logic                          sram_wen,
    output logic [$clog2(BANK_WORDS)-1:0] sram_addr,
    output logic [31:0]                   sram_wdata,
    input  logic [NUM_BANKS*32-1:0]       sram_rdata
);

    localparam int unsigned AW = $clog2(NUM_BANKS * BANK_WORDS);
    localparam int unsigned IW = $clog2(BANK_WORDS);
    localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_WB
    } owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, last_grant_q, grant_owner;
    logic [BW-1:0]   bank_q;
    logic [IW-1:0]   idx_q;
    logic            oor_q;
    logic [3:0]      mask_q;
    logic [31:0]     wdata_q;

    logic            wb_req;
    logic            any_req;
    logic [31:0]     sel_addr;
    logic [3:0]      sel_mask;
    logic [31:0]     sel_wdata;
    logic            sel_oor;
    logic [AW-1:0]   sel_word;
    logic [BW-1:0]   sel_bank;

    logic [31:0]          bank_rdata;
    logic [NUM_BANKS-1:0] bank_onehot;
    logic [31:0]          merged;

    // Request decode and round-robin tie break
    always_comb begin
        wb_req  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:16] == WB_BASE);
        any_req = cpu_req || wb_req;
        if (cpu_req && wb_req) begin
            grant_owner = (last_grant_q == OWN_CPU) ? OWN_WB : OWN_CPU;
        end else if (wb_req) begin
            grant_owner = OWN_WB;
        end else begin
            grant_owner = OWN_CPU;
        end
        if (grant_owner == OWN_WB) begin
            // Window bits are stripped so only the offset takes part in the range check
            sel_addr  = {16'h0000, wbs_adr_i[15:0]};
            sel_mask  = wbs_sel_i & {4{wbs_we_i}};
            sel_wdata = wbs_dat_i;
        end else begin
            sel_addr  = cpu_addr;
            sel_mask  = cpu_wmask;
            sel_wdata = cpu_wdata;
        end
        sel_oor  = |(sel_addr >> (AW + 2));
        sel_word = sel_addr[AW+1:2];
    end

    if (NUM_BANKS > 1) begin : g_bank
        assign sel_bank = sel_word[AW-1:IW];
    end else begin : g_single
        assign sel_bank = '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_WB;
            bank_q       <= '0;
            idx_q        <= '0;
            oor_q        <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
        end else if (state_q == S_IDLE && any_req) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            bank_q       <= sel_bank;
            idx_q        <= sel_word[IW-1:0];
            oor_q        <= sel_oor;
            mask_q       <= sel_mask;
            wdata_q      <= sel_wdata;
        end
    end

    always_comb begin
        bank_rdata  = '0;
        bank_onehot = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BW'(b)) begin
                bank_rdata     = sram_rdata[32*b +: 32];
                bank_onehot[b] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask_q[i] ? wdata_q[8*i +: 8] : bank_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        sram_en    = '0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        wbs_ack_o  = 1'b0;
        wbs_dat_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                sram_en   = oor_q ? '0 : bank_onehot;
                sram_addr = idx_q;
                if (mask_q == 4'hF) begin
                    sram_wen   = !oor_q;
                    sram_wdata = wdata_q;
                    state_d    = S_DONE;
                end else if (mask_q == 4'h0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                sram_en    = oor_q ? '0 : bank_onehot;
                sram_wen   = !oor_q;
                sram_addr  = idx_q;
                sram_wdata = merged;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (owner_q == OWN_CPU) begin
                    cpu_ack = 1'b1;
                    if (mask_q == 4'h0 && !oor_q) begin
                        cpu_rdata = bank_rdata;
                    end
                end else begin
                    wbs_ack_o = 1'b1;
                    if (mask_q == 4'h0 && !oor_q) begin
                        wbs_dat_o = bank_rdata;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/mimi_sram_arbiter.md
Name: mimi_sram_arbiter

Overview:
Parametrised banked-SRAM controller that replaces the fixed four-bank glue around the minimax core. It arbitrates between a CPU data port and a Wishbone slave port, both targeting NUM_BANKS word-wide SRAM macros. The SRAM macros support only full-word writes, so byte-masked writes are performed as read-modify-write. Every transaction returns a proper single-cycle acknowledge.

Parameters:
NUM_BANKS, 4, number of SRAM banks (power of two, 1..16)
BANK_WORDS, 512, 32-bit words per bank (power of two)
WB_BASE, 16'h3000, Wishbone window match on wbs_adr_i[31:16]
AW, $clog2(NUM_BANKS*BANK_WORDS), word-address width (derived, not overridable)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU request, held until cpu_ack
cpu_addr  in  32  CPU byte address
cpu_wmask  in  4  byte write mask; 0 = read
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  CPU read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control
wbs_sel_i  in  4  Wishbone byte select
wbs_adr_i  in  32  Wishbone byte address
wbs_dat_i  in  32  Wishbone write data
wbs_dat_o  out  32  Wishbone read data, valid with wbs_ack_o
wbs_ack_o  out  1  one-cycle acknowledge
sram_en  out  NUM_BANKS  per-bank enable, one-hot or zero
sram_wen  out  1  write enable, qualified by sram_en
sram_addr  out  $clog2(BANK_WORDS)  shared word index
sram_wdata  out  32  shared write data
sram_rdata  in  NUM_BANKS*32  flattened bank read data; bank b at [32b+:32]; valid the cycle after a read strobe

Behaviour:
- Reset (wb_rst_i low, async): state IDLE, all outputs 0, last_grant = WB, so the CPU wins the first tie.
- Requests: CPU when cpu_req = 1. WB when wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:16] == WB_BASE. WB mask = wbs_sel_i & {4{wbs_we_i}}.
- Word address = addr[AW+1:2]. Bank = upper log2(NUM_BANKS) bits of the word address. Index = the lower bits. Byte-address bits [1:0] are ignored.
- Out of range (any addr bit above AW+1 set, other than WB_BASE bits on WB): no sram_en. Read returns 32'h0. Write is dropped. The ack is still issued on the normal schedule.
- Arbitration in IDLE: if one requester is active, it is granted. If both are active, grant alternates (round-robin): the side not in last_grant wins. The losing request stays pending; it is never dropped.
- States: IDLE -> ACCESS -> [MERGE] -> DONE -> IDLE.
- IDLE: sample the winning request; latch addr, mask, wdata and owner into registers.
- ACCESS:
  - mask == 4'hF: drive the write strobe with latched data, then go to DONE.
  - mask == 0: drive the read strobe, then go to DONE.
  - partial mask: drive the read strobe, then go to MERGE.
- MERGE: merge per byte (mask ? wdata : sram_rdata of the selected bank), drive the write strobe, then go to DONE.
- DONE: assert the owner's ack for exactly one cycle. Read data comes from the selected bank's sram_rdata, registered into cpu_rdata or wbs_dat_o. For writes, the data output is 0. Return to IDLE.
- Latency from request sampled in IDLE to ack:
  - read: ack 2 cycles later
  - full write: ack 2 cycles later
  - partial write: ack 3 cycles later
- Back-to-back throughput is one transaction per 3 cycles (4 for partial).
- The non-owner's ack never asserts. cpu_ack and wbs_ack_o are never high together.
- SRAM strobes assert only in ACCESS or MERGE. sram_en is 0 in IDLE and DONE.
- The WB master dropping stb mid-transaction does not abort it; the ack is still pulsed. A new request is only sampled in IDLE.
- Reset mid-transaction: immediate return to IDLE, strobes and acks forced low. No partial RMW write may complete after reset asserts.

Test Plan:
- CPU full write then read: write addr 0x0000_0804 = 0xDEADBEEF (mask F). Required: sram_en = 4'b0010, sram_addr = 1, ack 2 cycles after request. Reading it back returns 0xDEADBEEF; ack 2 cycles after request.
- Partial write: preload 0x11223344 at word 5 of bank 0, then CPU writes 0xAABBCCDD with mask 4'b0101. Required: read strobe, then write strobe with 0x11BB33DD. Ack 3 cycles after request.
- Contention: CPU and WB both request in the same cycle after reset. Required: CPU is served first, then WB. Next simultaneous pair: WB is served first. No ack is lost.
- Wishbone window: WB read at 0x3000_1FFC returns the bank 3 index 511 contents. WB read at 0x3001_0000 is ignored (no ack). CPU read at 0x0000_2000 (out of range) acks with 0 and has no sram_en.
- Reset during MERGE: assert wb_rst_i low in the MERGE cycle. Required: no sram_wen, no ack. Memory word is unchanged and the state returns to IDLE.
- Parametrisation: NUM_BANKS = 8, BANK_WORDS = 256. Write to 0x0000_1C00 selects bank 7, index 0. Write to 0x0000_2000 is out of range.
